// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - microwave MM:SS countdown sequencer: chain load/enable/clear, 1 Hz tick, magnetron gate
// Optional done beeper enabled by defining TIMER_CTRL_BEEP_EN.
module timer_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int DONE_CYCLES = 100_000_000
`ifdef TIMER_CTRL_BEEP_EN
  ,
  parameter int BEEP_DIV    = 12_500_000
`endif
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       load_req,
  input  logic       timer_zero,
  output logic       cnt_loadn,
  output logic       cnt_en,
  output logic       cnt_clearn,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
`ifdef TIMER_CTRL_BEEP_EN
  ,
  output logic       beep
`endif
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DONE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          cur;
  state_t          nxt;
  logic            start_q;
  logic            stop_q;
  logic            armed;
  logic            start_r;
  logic            stop_r;
  logic            clear_req;
  logic [TW-1:0]   pres;
  logic            pres_wrap;
  logic [DW-1:0]   hold;
  logic            hold_last;

  // armed stays low for the first clock after reset so a key held through reset gives no edge
  assign start_r   = armed & start & ~start_q;
  assign stop_r    = armed & stop & ~stop_q;
  assign pres_wrap = (pres == TW'(TICK_DIV - 1));
  assign hold_last = (hold == DW'(DONE_CYCLES - 1));
  assign state     = cur;

  always_comb begin
    nxt       = cur;
    clear_req = 1'b0;
    case (cur)
      S_IDLE: begin
        if (stop_r)
          clear_req = 1'b1;
        else if (load_req)
          nxt = S_LOAD;
        else if (start_r && door_closed && !timer_zero)
          nxt = S_RUN;
      end
      S_LOAD: nxt = S_IDLE;
      S_RUN: begin
        if (timer_zero)
          nxt = S_DONE;
        else if (!door_closed || stop_r)
          nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop_r) begin
          nxt       = S_IDLE;
          clear_req = 1'b1;
        end else if (start_r && door_closed) begin
          nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (stop_r || !door_closed || hold_last)
          nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      cur     <= S_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      cur     <= nxt;
      start_q <= start;
      stop_q  <= stop;
      armed   <= 1'b1;
    end
  end

  // Prescaler only advances on RUN->RUN steps, so a pause keeps the partial second intact
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      pres <= '0;
    end else if (cur == S_IDLE) begin
      pres <= '0;
    end else if (cur == S_RUN && nxt == S_RUN) begin
      pres <= pres_wrap ? '0 : pres + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn)
      hold <= '0;
    else if (cur != S_DONE)
      hold <= '0;
    else
      hold <= hold + 1'b1;
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      cnt_loadn  <= 1'b1;
      cnt_en     <= 1'b0;
      cnt_clearn <= 1'b1;
      mag_on     <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt_loadn  <= (nxt != S_LOAD);
      cnt_en     <= (cur == S_RUN) && (nxt == S_RUN) && pres_wrap;
      cnt_clearn <= !clear_req;
      mag_on     <= (nxt == S_RUN);
      done       <= (nxt == S_DONE);
    end
  end

`ifdef TIMER_CTRL_BEEP_EN
  localparam int BW = $clog2(BEEP_DIV + 1);
  logic [BW-1:0] bcnt;

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      beep <= 1'b0;
      bcnt <= '0;
    end else if (nxt != S_DONE) begin
      beep <= 1'b0;
      bcnt <= '0;
    end else if (cur != S_DONE) begin
      beep <= 1'b1;
      bcnt <= '0;
    end else if (bcnt == BW'(BEEP_DIV - 1)) begin
      beep <= ~beep;
      bcnt <= '0;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
`endif

endmodule
